// File: rtl/alu_sched_pkg.sv
// rtl/alu_sched_pkg.sv - shared types and constants for the shared-ALU scheduler
package alu_sched_pkg;

    localparam int OP_W         = 4;
    localparam int DATA_W_DEF   = 16;
    // WAIT_BUSY cycles without busy before an op is treated as single-cycle
    localparam int BUSY_TIMEOUT = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAKE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_RESP
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with last-grant pointer, one-hot grant
module rr_arbiter #(
    parameter int NREQ = 2,
    localparam int IW  = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_id
);

    logic [IW-1:0] last;
    logic          found;
    int            idx;

    // Search starts just after the previous winner
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last) + k) % NREQ;
            if (!found && req[idx]) begin
                found    = 1'b1;
                grant_id = IW'(idx);
            end
        end
        if (en && found) begin
            grant[grant_id] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= IW'(NREQ - 1);
        end else if (en && found) begin
            last <= grant_id;
        end
    end

endmodule

// File: rtl/alu_sched.sv
// rtl/alu_sched.sv - shared-ALU scheduler with round-robin grant and idle clock gating
// Idle gating and the WAKE state exist only when ALU_SCHED_CLKGATE_EN is defined.
module alu_sched
    import alu_sched_pkg::*;
#(
    parameter int NREQ     = 2,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int IDLE_CYC = 8,
    parameter int WAKE_CYC = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*DATA_W-1:0]   req_a,
    input  logic [NREQ*DATA_W-1:0]   req_b,
    input  logic [NREQ*OP_W-1:0]     req_op,
    output logic [NREQ-1:0]          req_ready,
    output logic [DATA_W-1:0]        alu_a,
    output logic [DATA_W-1:0]        alu_b,
    output logic [OP_W-1:0]          alu_opcode,
    output logic                     alu_start,
    input  logic                     alu_busy,
    input  logic [DATA_W-1:0]        alu_result,
    output logic                     diss_clk,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [DATA_W-1:0]        rsp_result
);

    localparam int IW = $clog2(NREQ);

    state_t        state, state_nx;
    logic          grant_en;
    logic          gated;
    logic          wake_done;
    logic [1:0]    wb_cnt;
    logic [IW-1:0] grant_id;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req_valid),
        .en       (grant_en && rst_n),
        .grant    (req_ready),
        .grant_id (grant_id)
    );

`ifdef ALU_SCHED_CLKGATE_EN
    localparam int ICW = $clog2(IDLE_CYC + 1);
    localparam int WCW = $clog2(WAKE_CYC + 1);

    logic [ICW-1:0] idle_cnt;
    logic [WCW-1:0] wake_cnt;

    assign gated = diss_clk;
    // WAKE lasts WAKE_CYC+1 cycles so the grant lands WAKE_CYC+2 cycles after the waking request
    assign wake_done = (wake_cnt == WCW'(WAKE_CYC));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
            wake_cnt <= '0;
            diss_clk <= 1'b0;
        end else begin
            wake_cnt <= (state == S_WAKE) ? wake_cnt + 1'b1 : '0;
            if (state == S_IDLE && req_valid == '0) begin
                if (idle_cnt != ICW'(IDLE_CYC)) idle_cnt <= idle_cnt + 1'b1;
                if (idle_cnt == ICW'(IDLE_CYC - 1)) diss_clk <= 1'b1;
            end else begin
                idle_cnt <= '0;
                if (state == S_IDLE && diss_clk) diss_clk <= 1'b0;
            end
        end
    end
`else
    logic unused_cfg;

    assign gated      = 1'b0;
    assign wake_done  = 1'b1;
    assign diss_clk   = 1'b0;
    assign unused_cfg = (IDLE_CYC > 0) && (WAKE_CYC > 0);
`endif

    always_comb begin
        state_nx = state;
        grant_en = 1'b0;
        case (state)
            S_IDLE: begin
                if (|req_valid) begin
                    if (gated) begin
                        state_nx = S_WAKE;
                    end else begin
                        grant_en = 1'b1;
                        state_nx = S_ISSUE;
                    end
                end
            end
            S_WAKE:      if (wake_done) state_nx = S_IDLE;
            S_ISSUE:     state_nx = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (alu_busy) state_nx = S_WAIT_DONE;
                else if (wb_cnt == 2'(BUSY_TIMEOUT - 1)) state_nx = S_RESP;
            end
            S_WAIT_DONE: if (!alu_busy) state_nx = S_RESP;
            S_RESP:      if (rsp_ready) state_nx = S_IDLE;
            default:     state_nx = S_IDLE;
        endcase
    end

    assign alu_start = (state == S_ISSUE);
    assign rsp_valid = (state == S_RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            rsp_id     <= '0;
            rsp_result <= '0;
            wb_cnt     <= '0;
        end else begin
            state  <= state_nx;
            wb_cnt <= (state == S_WAIT_BUSY) ? wb_cnt + 1'b1 : 2'd0;
            if (|req_ready) begin
                alu_a      <= req_a[grant_id*DATA_W +: DATA_W];
                alu_b      <= req_b[grant_id*DATA_W +: DATA_W];
                alu_opcode <= req_op[grant_id*OP_W +: OP_W];
                rsp_id     <= grant_id;
            end
            if (state_nx == S_RESP && state != S_RESP) begin
                rsp_result <= alu_result;
            end
        end
    end

endmodule
